// File: rtl/cp0_wr_sched_pkg.sv
// Shared types for the CP0 write scheduler: FSM states and request counting.
// Latency: n/a. Backpressure: n/a.
package cp0_wr_sched_pkg;

  localparam int CP0_ADDR_W = 5;
  localparam int WORD_W     = 32;

  typedef enum logic [1:0] {
    CP0S_RUN   = 2'd0,
    CP0S_DRAIN = 2'd1,
    CP0S_GRANT = 2'd2
  } cp0s_t;

  function automatic logic [1:0] req_count(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/cp0_wr_fifo.sv
// DEPTH-entry FIFO, two writes (slot0 first) and one read per cycle, head popped whenever non-empty.
// Latency: entry written at edge N is the head during cycle N+1. Backpressure: caller must not overfill.
// All entries are exposed in age order (index 0 = oldest) for read forwarding.
module cp0_wr_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push0,
  input  logic [ADDR_W-1:0]      push0_addr,
  input  logic [31:0]            push0_dat,
  input  logic                   push1,
  input  logic [ADDR_W-1:0]      push1_addr,
  input  logic [31:0]            push1_dat,
  output logic                   head_vld,
  output logic [ADDR_W-1:0]      head_addr,
  output logic [31:0]            head_dat,
  output logic [$clog2(DEPTH):0] count,
  output logic [DEPTH-1:0]       ent_vld,
  output logic [ADDR_W-1:0]      ent_addr [DEPTH],
  output logic [31:0]            ent_dat  [DEPTH]
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]     rd_ptr, wr_ptr, wr_ptr_nx1;
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [31:0]       mem_dat  [DEPTH];
  logic              pop, wr0_en, wr1_en;
  logic [ADDR_W-1:0] wr0_addr;
  logic [31:0]       wr0_dat;
  logic [CW-1:0]     n_enq;

  // A lone slot1 request takes the first free entry, just like slot0 would.
  assign pop        = (count != '0);
  assign wr0_en     = push0 | push1;
  assign wr1_en     = push0 & push1;
  assign wr0_addr   = push0 ? push0_addr : push1_addr;
  assign wr0_dat    = push0 ? push0_dat : push1_dat;
  assign wr_ptr_nx1 = wr_ptr + PW'(1);
  assign n_enq      = CW'(wr0_en) + CW'(wr1_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(pop);
      wr_ptr <= wr_ptr + PW'(n_enq);
      count  <= count + n_enq - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (wr0_en) begin
      mem_addr[wr_ptr] <= wr0_addr;
      mem_dat[wr_ptr]  <= wr0_dat;
    end
    if (wr1_en) begin
      mem_addr[wr_ptr_nx1] <= push1_addr;
      mem_dat[wr_ptr_nx1]  <= push1_dat;
    end
  end

  assign head_vld  = pop;
  assign head_addr = mem_addr[rd_ptr];
  assign head_dat  = mem_dat[rd_ptr];

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic [PW-1:0] idx;
    assign idx         = rd_ptr + PW'(g);
    assign ent_vld[g]  = (CW'(g) < count);
    assign ent_addr[g] = mem_addr[idx];
    assign ent_dat[g]  = mem_dat[idx];
  end

endmodule

// File: rtl/cp0_wr_sched.sv
// CP0 write-port scheduler: queues MTC0 writes from both slots, drains one per cycle, forwards MFC0 reads.
// Latency: accepted write reaches cp0_we the next cycle (empty queue); reads are combinational.
// Backpressure: all-or-nothing accept, wr_stall when space short or exception drain; CP0_WBUF_BYPASS_EN enables forwarding.
module cp0_wr_sched
  import cp0_wr_sched_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = CP0_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s0_wc0,
  input  logic [ADDR_W-1:0] s0_addr,
  input  logic [31:0]       s0_wdata,
  input  logic              s1_wc0,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [31:0]       s1_wdata,
  output logic              wr_stall,
  output logic              cp0_we,
  output logic [ADDR_W-1:0] cp0_waddr,
  output logic [31:0]       cp0_wdata,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       cp0_rdata_i,
  output logic [31:0]       rd_data,
  output logic              rd_stall,
  input  logic              exc_req,
  output logic              exc_grant
);
`ifdef CP0_WBUF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  cp0s_t             state_q, state_d;
  logic [1:0]        n_req;
  logic              accept, push0, push1;
  logic              head_vld;
  logic [ADDR_W-1:0] head_addr;
  logic [31:0]       head_dat;
  logic [$clog2(DEPTH):0] count;
  logic [DEPTH-1:0]  ent_vld;
  logic [ADDR_W-1:0] ent_addr [DEPTH];
  logic [31:0]       ent_dat  [DEPTH];
  logic              fifo_hit, s0_hit, s1_hit, mem_hit;
  logic [WORD_W-1:0] fifo_dat;

  // Space check uses the registered count: a same-cycle pop is not credited.
  assign n_req    = req_count(s0_wc0, s1_wc0);
  assign accept   = (state_q == CP0S_RUN) && (int'(n_req) <= DEPTH - int'(count));
  assign wr_stall = (n_req != 2'd0) && !accept;
  assign push0    = s0_wc0 && accept;
  assign push1    = s1_wc0 && accept;

  cp0_wr_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push0      (push0),
    .push0_addr (s0_addr),
    .push0_dat  (s0_wdata),
    .push1      (push1),
    .push1_addr (s1_addr),
    .push1_dat  (s1_wdata),
    .head_vld   (head_vld),
    .head_addr  (head_addr),
    .head_dat   (head_dat),
    .count      (count),
    .ent_vld    (ent_vld),
    .ent_addr   (ent_addr),
    .ent_dat    (ent_dat)
  );

  assign cp0_we    = head_vld;
  assign cp0_waddr = head_vld ? head_addr : '0;
  assign cp0_wdata = head_vld ? head_dat : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= CP0S_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    exc_grant = 1'b0;
    case (state_q)
      CP0S_RUN:   if (exc_req) state_d = CP0S_DRAIN;
      CP0S_DRAIN: begin
        if (!exc_req)          state_d = CP0S_RUN;
        else if (count == '0)  state_d = CP0S_GRANT;
      end
      CP0S_GRANT: begin
        exc_grant = 1'b1;
        state_d   = CP0S_RUN;
      end
      default:    state_d = CP0S_RUN;
    endcase
  end

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fifo_hit = 1'b0;
    fifo_dat = cp0_rdata_i;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && (ent_addr[i] == rd_addr)) begin
        fifo_hit = 1'b1;
        fifo_dat = ent_dat[i];
      end
    end
  end

  assign s0_hit  = s0_wc0 && (s0_addr == rd_addr);
  assign s1_hit  = s1_wc0 && (s1_addr == rd_addr);
  assign mem_hit = s0_hit || s1_hit;

  always_comb begin
    rd_data  = cp0_rdata_i;
    rd_stall = 1'b0;
    if (BYPASS) begin
      rd_data = fifo_dat;
      if (mem_hit && wr_stall) rd_stall = 1'b1;
      else if (s1_hit)         rd_data  = s1_wdata;
      else if (s0_hit)         rd_data  = s0_wdata;
    end else begin
      rd_stall = mem_hit || fifo_hit;
    end
  end

endmodule

// File: tb/tb_cp0_wr_sched.sv
// Self-checking bench for cp0_wr_sched: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations, then randomized traffic.
module tb_cp0_wr_sched;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s0_wc0, s1_wc0, exc_req;
  logic [4:0]  s0_addr, s1_addr, rd_addr, cp0_waddr;
  logic [31:0] s0_wdata, s1_wdata, cp0_rdata_i, cp0_wdata, rd_data;
  logic        wr_stall, cp0_we, rd_stall, exc_grant;

  always #5 clk = ~clk;

  cp0_wr_sched #(.DEPTH(DEPTH), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_wc0(s0_wc0), .s0_addr(s0_addr), .s0_wdata(s0_wdata),
    .s1_wc0(s1_wc0), .s1_addr(s1_addr), .s1_wdata(s1_wdata),
    .wr_stall(wr_stall), .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
    .rd_addr(rd_addr), .cp0_rdata_i(cp0_rdata_i), .rd_data(rd_data), .rd_stall(rd_stall),
    .exc_req(exc_req), .exc_grant(exc_grant)
  );

  typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
  ent_t q[$];
  int   phase;              // 0 normal, 1 waiting for queue to empty, 2 grant cycle
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_accept();
    int n = int'(s0_wc0) + int'(s1_wc0);
    return (phase == 0) && (n <= DEPTH - q.size());
  endfunction

  task automatic compare();
    int          n = int'(s0_wc0) + int'(s1_wc0);
    bit          acc = model_accept();
    bit          e_wrst = (n != 0) && !acc;
    bit          fhit = 1'b0;
    logic [31:0] fdat = cp0_rdata_i;
    bit          m0 = s0_wc0 && (s0_addr == rd_addr);
    bit          m1 = s1_wc0 && (s1_addr == rd_addr);
    foreach (q[i]) if (q[i].a == rd_addr) begin fhit = 1'b1; fdat = q[i].d; end
    chk("wr_stall", 32'(wr_stall), 32'(e_wrst));
    chk("cp0_we", 32'(cp0_we), 32'(q.size() != 0));
    chk("cp0_waddr", 32'(cp0_waddr), q.size() != 0 ? 32'(q[0].a) : 32'd0);
    chk("cp0_wdata", cp0_wdata, q.size() != 0 ? q[0].d : 32'd0);
    chk("exc_grant", 32'(exc_grant), 32'(phase == 2));
`ifdef CP0_WBUF_BYPASS_EN
    chk("rd_stall", 32'(rd_stall), 32'((m0 || m1) && e_wrst));
    if (!((m0 || m1) && e_wrst))
      chk("rd_data", rd_data, m1 ? s1_wdata : (m0 ? s0_wdata : fdat));
`else
    chk("rd_stall", 32'(rd_stall), 32'(m0 || m1 || fhit));
    chk("rd_data", rd_data, cp0_rdata_i);
`endif
  endtask

  task automatic update();
    int  n0 = q.size();
    bit  acc = model_accept();
    if (!rst_n) begin
      q.delete();
      phase = 0;
      return;
    end
    if (n0 != 0) void'(q.pop_front());
    if (acc && s0_wc0) q.push_back('{a: s0_addr, d: s0_wdata});
    if (acc && s1_wc0) q.push_back('{a: s1_addr, d: s1_wdata});
    case (phase)
      0: if (exc_req) phase = 1;
      1: if (!exc_req) phase = 0; else if (n0 == 0) phase = 2;
      default: phase = 0;
    endcase
  endtask

  // Called at posedge+1 with inputs applied; compares mid-cycle, then advances model at the edge.
  task automatic step();
    cp0_rdata_i = $urandom;
    #2;
    compare();
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic idle();
    s0_wc0 = 0; s1_wc0 = 0; exc_req = 0;
    s0_addr = 0; s1_addr = 0; s0_wdata = 0; s1_wdata = 0;
    rd_addr = 5'd31;
  endtask

  task automatic wr2(input logic [4:0] a0, input logic [31:0] d0,
                     input logic [4:0] a1, input logic [31:0] d1);
    idle();
    s0_wc0 = 1; s0_addr = a0; s0_wdata = d0;
    s1_wc0 = 1; s1_addr = a1; s1_wdata = d1;
  endtask

  int grant_at, ngr;

  initial begin
    idle();
    cp0_rdata_i = 32'h1234_5678;
    rst_n = 0;
    phase = 0;
    #12;
    chk("rst_we", 32'(cp0_we), 32'd0);
    chk("rst_waddr", 32'(cp0_waddr), 32'd0);
    chk("rst_wdata", cp0_wdata, 32'd0);
    chk("rst_wr_stall", 32'(wr_stall), 32'd0);
    chk("rst_rd_stall", 32'(rd_stall), 32'd0);
    chk("rst_grant", 32'(exc_grant), 32'd0);
    chk("rst_rd_data", rd_data, cp0_rdata_i);
    @(posedge clk); #1;
    rst_n = 1;

    // Single write appears on the port one cycle later.
    idle(); s0_wc0 = 1; s0_addr = 5'd12; s0_wdata = 32'h0000_FF01; step();
    idle(); #1;
    chk("t1_we", 32'(cp0_we), 32'd1);
    chk("t1_waddr", 32'(cp0_waddr), 32'd12);
    chk("t1_wdata", cp0_wdata, 32'h0000_FF01);
    step();
    #1 chk("t1_we_off", 32'(cp0_we), 32'd0);
    step();

    // Full-ish FIFO: count=3 stalls a double write, count=2 accepts it.
    wr2(5'd1, 32'hA1, 5'd2, 32'hA2); step();
    wr2(5'd3, 32'hA3, 5'd4, 32'hA4); step();
    chk("t2_model_cnt3", 32'(q.size()), 32'd3);
    wr2(5'd5, 32'hA5, 5'd6, 32'hA6); #1;
    chk("t2_stall", 32'(wr_stall), 32'd1);
    step();
    chk("t2_model_cnt2", 32'(q.size()), 32'd2);
    #1 chk("t2_accept", 32'(wr_stall), 32'd0);
    step();
    idle(); #1 chk("t2_order0", 32'(cp0_waddr), 32'd4); step();
    #1 chk("t2_order1", 32'(cp0_waddr), 32'd5); step();
    #1 chk("t2_order2", 32'(cp0_waddr), 32'd6); step();
    step();

    // Forwarding: youngest FIFO entry, then same-cycle slot1 write.
    wr2(5'd11, 32'h1, 5'd11, 32'h2); step();
    idle(); rd_addr = 5'd11; #1;
`ifdef CP0_WBUF_BYPASS_EN
    chk("t3_fifo_fwd", rd_data, 32'h2);
    chk("t3_fifo_nostall", 32'(rd_stall), 32'd0);
    s1_wc0 = 1; s1_addr = 5'd11; s1_wdata = 32'h3; #1;
    chk("t3_mem_fwd", rd_data, 32'h3);
`else
    chk("t3_fifo_stall", 32'(rd_stall), 32'd1);
    chk("t3_raw", rd_data, cp0_rdata_i);
    s1_wc0 = 1; s1_addr = 5'd11; s1_wdata = 32'h3; #1;
    chk("t3_mem_stall", 32'(rd_stall), 32'd1);
`endif
    step();
    idle(); step(); step(); step();

    // Exception drain: two queued writes, held request, one-cycle grant at the 4th cycle.
    wr2(5'd7, 32'h77, 5'd8, 32'h88); step();
    grant_at = -1; ngr = 0;
    for (int k = 0; k < 5; k++) begin
      idle();
      exc_req = (k < 4);
      if (k > 0) begin s0_wc0 = 1; s0_addr = 5'd9; s0_wdata = 32'h99; end
      #1;
      if (k == 1) chk("t4_drain_stall", 32'(wr_stall), 32'd1);
      if (k == 4) chk("t4_run_accept", 32'(wr_stall), 32'd0);
      if (exc_grant) begin
        if (grant_at < 0) grant_at = k;
        ngr++;
      end
      step();
    end
    chk("t4_grant_cycle", 32'(grant_at), 32'd3);
    chk("t4_grant_count", 32'(ngr), 32'd1);
    idle(); step(); step();

    // Reset with three pending writes discards them.
    wr2(5'd1, 32'hB1, 5'd2, 32'hB2); step();
    wr2(5'd3, 32'hB3, 5'd4, 32'hB4); step();
    idle(); #1;
    rst_n = 0; q.delete(); phase = 0;
    #1;
    chk("t5_we_in_rst", 32'(cp0_we), 32'd0);
    step(); step();
    rst_n = 1;
    #1 chk("t5_no_stale", 32'(cp0_we), 32'd0);
    step(); step();

    // Pending write to the read address, then drained.
    idle(); s0_wc0 = 1; s0_addr = 5'd12; s0_wdata = 32'hCAFE; step();
    idle(); rd_addr = 5'd12; #1;
`ifdef CP0_WBUF_BYPASS_EN
    chk("t6_fwd", rd_data, 32'hCAFE);
    chk("t6_nostall", 32'(rd_stall), 32'd0);
`else
    chk("t6_stall", 32'(rd_stall), 32'd1);
`endif
    step();
    #1;
    chk("t6_drained", 32'(rd_stall), 32'd0);
    chk("t6_raw", rd_data, cp0_rdata_i);
    step();

    // Randomized traffic on a small address space to provoke matches.
    idle();
    for (int n = 0; n < 3000; n++) begin
      s0_wc0   = ($urandom_range(0, 2) != 0);
      s1_wc0   = ($urandom_range(0, 2) != 0);
      s0_addr  = 5'($urandom_range(0, 7));
      s1_addr  = 5'($urandom_range(0, 7));
      s0_wdata = $urandom;
      s1_wdata = $urandom;
      rd_addr  = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) exc_req = ~exc_req;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
